// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline: opcodes, the NOP encoding,
// front-end stage states and the word-indexed JAL offset helper.
package rv_pipe_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_HALT   = 7'h7F;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SQUASH,
        ST_HALTED
    } stage_state_e;

    // sext(J-imm) >>> 2: the byte offset's low two bits are dropped, leaving imm[20:2]
    function automatic logic [31:0] jal_word_offset(input logic [31:0] instr);
        return {{13{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:22]};
    endfunction

endpackage

// File: rtl/rv_operand_use.sv
// Extracts the source register fields of an instruction and flags which of them
// the opcode actually reads.
module rv_operand_use
    import rv_pipe_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        rs1_used,
    output logic        rs2_used
);

    logic [6:0] opcode;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign rs1_used = !((opcode == OPC_JAL) || (opcode == OPC_LUI) || (opcode == OPC_AUIPC));

    assign unused_fields = ^{instr[31:25], instr[14:7]};

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register plus the front-end hazard controller that steers the
// program server (redirects, load-use stalls, HALT).
module if_id_stage
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0] NOP      = NOP_INSTR,
    parameter logic [6:0]  HALT_OPC = OPC_HALT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hlt,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_nextpc,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    output logic        jump,
    output logic [31:0] next,
    output logic        stall,
    output logic        bubble,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_nextpc,
    output logic        id_valid,
    output logic        id_kill
);

    stage_state_e state_q, state_d;
    logic [31:0]  id_instr_q, id_pc_q, id_nextpc_q;
    logic         id_valid_q;

    logic [4:0]   rs1, rs2;
    logic         rs1_used, rs2_used;
    logic         load_use, is_jal, is_halt;
    logic         jump_d, stall_d, bubble_d, kill_d, load_if_d, load_nop_d;
    logic [31:0]  next_d;

    rv_operand_use u_operand_use (
        .instr    (id_instr_q),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    assign load_use = id_valid_q && ex_mem_read && (ex_rd != 5'd0) &&
                      ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));
    assign is_jal   = id_valid_q && (id_instr_q[6:0] == OPC_JAL);
    assign is_halt  = id_valid_q && (id_instr_q[6:0] == HALT_OPC);

    always_comb begin
        jump_d     = 1'b0;
        next_d     = '0;
        stall_d    = 1'b0;
        bubble_d   = 1'b0;
        kill_d     = 1'b0;
        load_if_d  = 1'b0;
        load_nop_d = 1'b0;
        state_d    = (state_q == ST_SQUASH) ? ST_RUN : state_q;

        if (hlt) begin
            state_d = state_q;
        end else if (state_q == ST_HALTED) begin
            bubble_d = 1'b1;
        end else if (ex_redirect) begin
            // EX redirect outranks a JAL in ID: that JAL is on the wrong path
            jump_d     = 1'b1;
            next_d     = ex_target;
            state_d    = ST_SQUASH;
            load_nop_d = 1'b1;
        end else if (load_use) begin
            stall_d = 1'b1;
            kill_d  = 1'b1;
        end else if (is_jal) begin
            jump_d     = 1'b1;
            next_d     = id_pc_q + jal_word_offset(id_instr_q);
            state_d    = ST_SQUASH;
            load_nop_d = 1'b1;
        end else if (is_halt) begin
            state_d = ST_HALTED;
        end else begin
            load_if_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            id_instr_q  <= NOP;
            id_pc_q     <= 32'd0;
            id_nextpc_q <= 32'd1;
            id_valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_nop_d) begin
                id_instr_q <= NOP;
                id_valid_q <= 1'b0;
            end else if (load_if_d) begin
                id_instr_q  <= if_instruction;
                id_pc_q     <= if_pc;
                id_nextpc_q <= if_nextpc;
                id_valid_q  <= 1'b1;
            end
        end
    end

    // Control outputs are forced low while reset is held
    assign jump    = rst_n & jump_d;
    assign next    = rst_n ? next_d : 32'd0;
    assign stall   = rst_n & stall_d;
    assign bubble  = rst_n & bubble_d;
    assign id_kill = rst_n & kill_d;

    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_nextpc = id_nextpc_q;
    assign id_valid  = id_valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed, table-driven bench for if_id_stage: one row per cycle with expected
// control outputs before the edge and expected IF/ID contents after it.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n, hlt;
    logic [31:0] if_instruction, if_pc, if_nextpc;
    logic [4:0]  ex_rd;
    logic        ex_mem_read, ex_redirect;
    logic [31:0] ex_target;
    logic        jump, stall, bubble, id_valid, id_kill;
    logic [31:0] next, id_instr, id_pc, id_nextpc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hlt            (hlt),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_nextpc      (if_nextpc),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_redirect    (ex_redirect),
        .ex_target      (ex_target),
        .jump           (jump),
        .next           (next),
        .stall          (stall),
        .bubble         (bubble),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_nextpc      (id_nextpc),
        .id_valid       (id_valid),
        .id_kill        (id_kill)
    );

    typedef struct packed {
        logic        hlt;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  ex_rd;
        logic        mem_rd;
        logic        redir;
        logic [31:0] target;
        logic        e_jump;
        logic [31:0] e_next;
        logic        e_stall;
        logic        e_bubble;
        logic        e_kill;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        chk_pc;
    } vec_t;

    vec_t vecs [0:18];

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL row%0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    // Drives one cycle: comb outputs checked mid-low-phase, register checked after the edge
    task automatic apply(input int row, input vec_t v);
        hlt            = v.hlt;
        if_instruction = v.instr;
        if_pc          = v.pc;
        if_nextpc      = v.pc + 32'd1;
        ex_rd          = v.ex_rd;
        ex_mem_read    = v.mem_rd;
        ex_redirect    = v.redir;
        ex_target      = v.target;
        #2;
        check("jump",    row, {31'd0, jump},    {31'd0, v.e_jump});
        check("next",    row, next,             v.e_next);
        check("stall",   row, {31'd0, stall},   {31'd0, v.e_stall});
        check("bubble",  row, {31'd0, bubble},  {31'd0, v.e_bubble});
        check("id_kill", row, {31'd0, id_kill}, {31'd0, v.e_kill});
        @(posedge clk);
        #1;
        check("id_instr", row, id_instr,          v.e_instr);
        check("id_valid", row, {31'd0, id_valid}, {31'd0, v.e_valid});
        if (v.chk_pc) begin
            check("id_pc",     row, id_pc,     v.e_pc);
            check("id_nextpc", row, id_nextpc, v.e_pc + 32'd1);
        end
        $display("row%0d instr=%h pc=%0d jump=%b next=%0d stall=%b bubble=%b id_instr=%h id_valid=%b",
                 row, v.instr, v.pc, jump, next, stall, bubble, id_instr, id_valid);
        @(negedge clk);
    endtask

    initial begin
        //           hlt instr          pc  rd mr rdr tgt  jmp nxt st bb kl  e_instr        e_pc v  cpc
        vecs[0]  = '{1'b0, 32'h00100093,  0,  0, 0, 0,  0,  0,  0, 0, 0, 0, 32'h00100093,  0, 1, 1};
        vecs[1]  = '{1'b0, 32'h014000ef,  1,  0, 0, 0,  0,  0,  0, 0, 0, 0, 32'h014000ef,  1, 1, 1};
        vecs[2]  = '{1'b0, 32'h00200113,  2,  0, 0, 0,  0,  1,  6, 0, 0, 0, 32'h00000013,  0, 0, 0};
        vecs[3]  = '{1'b0, 32'h00600193,  6,  0, 0, 0,  0,  0,  0, 0, 0, 0, 32'h00600193,  6, 1, 1};
        vecs[4]  = '{1'b0, 32'h02550533,  7,  0, 0, 0,  0,  0,  0, 0, 0, 0, 32'h02550533,  7, 1, 1};
        vecs[5]  = '{1'b0, 32'h00000213,  8, 10, 1, 0,  0,  0,  0, 1, 0, 1, 32'h02550533,  7, 1, 1};
        vecs[6]  = '{1'b0, 32'h00000213,  8,  0, 1, 0,  0,  0,  0, 0, 0, 0, 32'h00000213,  8, 1, 1};
        vecs[7]  = '{1'b0, 32'hfe1ff0ef,  9,  0, 0, 0,  0,  0,  0, 0, 0, 0, 32'hfe1ff0ef,  9, 1, 1};
        vecs[8]  = '{1'b0, 32'h00000013, 10,  0, 0, 1, 14,  1, 14, 0, 0, 0, 32'h00000013,  0, 0, 0};
        vecs[9]  = '{1'b0, 32'h0000007f, 14,  0, 0, 0,  0,  0,  0, 0, 0, 0, 32'h0000007f, 14, 1, 1};
        vecs[10] = '{1'b0, 32'h00000013, 15,  0, 0, 0,  0,  0,  0, 0, 0, 0, 32'h0000007f, 14, 1, 1};
        vecs[11] = '{1'b0, 32'h00000013, 16,  0, 0, 1,  3,  0,  0, 0, 1, 0, 32'h0000007f, 14, 1, 1};
        vecs[12] = '{1'b1, 32'h00000013, 16,  0, 0, 0,  0,  0,  0, 0, 0, 0, 32'h0000007f, 14, 1, 1};
        vecs[13] = '{1'b0, 32'h00000013, 16,  0, 0, 0,  0,  0,  0, 0, 1, 0, 32'h0000007f, 14, 1, 1};
        // after a mid-run reset: normal fetch, then a JAL held off by hlt
        vecs[14] = '{1'b0, 32'h00100093,  0,  0, 0, 0,  0,  0,  0, 0, 0, 0, 32'h00100093,  0, 1, 1};
        vecs[15] = '{1'b0, 32'h014000ef,  1,  0, 0, 0,  0,  0,  0, 0, 0, 0, 32'h014000ef,  1, 1, 1};
        vecs[16] = '{1'b1, 32'h00200113,  2,  0, 0, 0,  0,  0,  0, 0, 0, 0, 32'h014000ef,  1, 1, 1};
        vecs[17] = '{1'b0, 32'h00200113,  2,  0, 0, 0,  0,  1,  6, 0, 0, 0, 32'h00000013,  0, 0, 0};
        vecs[18] = '{1'b0, 32'h00600193,  6,  0, 0, 0,  0,  0,  0, 0, 0, 0, 32'h00600193,  6, 1, 1};

        // Reset with live-looking inputs: control outputs must stay low
        rst_n = 1'b0;
        hlt = 1'b0;
        if_instruction = 32'h014000ef;
        if_pc = 32'd5;
        if_nextpc = 32'd6;
        ex_rd = 5'd3;
        ex_mem_read = 1'b1;
        ex_redirect = 1'b1;
        ex_target = 32'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_id_instr",  -1, id_instr,            32'h00000013);
        check("rst_id_pc",     -1, id_pc,               32'd0);
        check("rst_id_nextpc", -1, id_nextpc,           32'd1);
        check("rst_id_valid",  -1, {31'd0, id_valid},   32'd0);
        check("rst_jump",      -1, {31'd0, jump},       32'd0);
        check("rst_next",      -1, next,                32'd0);
        $display("reset id_instr=%h id_pc=%0d id_valid=%b jump=%b", id_instr, id_pc, id_valid, jump);
        rst_n = 1'b1;

        for (int i = 0; i <= 13; i++) apply(i, vecs[i]);

        // Asynchronous reset pulse between edges while HALTED
        #2;
        hlt = 1'b0;
        ex_redirect = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_id_instr", 99, id_instr,           32'h00000013);
        check("async_id_pc",    99, id_pc,              32'd0);
        check("async_id_valid", 99, {31'd0, id_valid},  32'd0);
        check("async_bubble",   99, {31'd0, bubble},    32'd0);
        $display("async reset id_instr=%h id_pc=%0d id_valid=%b bubble=%b", id_instr, id_pc, id_valid, bubble);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 14; i <= 18; i++) apply(i, vecs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline register and front-end hazard controller for the 5-stage RISC-V pipeline. It sits directly downstream of the program server. Each cycle it captures the served instruction, PC and nextPC. It drives the server's `jump`/`next`/`stall`/`bubble` controls back, which lets it resolve control flow (JAL in ID, branch/JALR redirects from EX), load-use stalls and HALT.

## Interface
Parameters:
- `NOP`, 32'h00000013, instruction inserted on squash/reset
- `HALT_OPC`, 7'h7F, opcode that freezes fetch

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `hlt`  in  1  global processor halt; freezes this block
- `if_instruction`  in  32  instruction from program server
- `if_pc`  in  32  word-indexed PC of `if_instruction`
- `if_nextpc`  in  32  `if_pc`+1
- `ex_rd`  in  5  destination register of the instruction in EX
- `ex_mem_read`  in  1  the instruction in EX is a load
- `ex_redirect`  in  1  a branch or JALR taken in EX
- `ex_target`  in  32  word-indexed redirect target
- `jump`  out  1  to program server: load `next`
- `next`  out  32  redirect address
- `stall`  out  1  to program server: load-use stall request
- `bubble`  out  1  to program server: freeze PC (halted)
- `id_instr`  out  32  registered instruction in ID
- `id_pc`  out  32  registered PC
- `id_nextpc`  out  32  registered PC+1, used as the JAL/JALR link value
- `id_valid`  out  1  ID holds a real (non-squashed) instruction
- `id_kill`  out  1  downstream must insert NOP into ID/EX this cycle

## Operation
- State machine with three states: RUN, SQUASH, HALTED. Reset state is RUN.
- Reset values: `id_instr`=NOP, `id_pc`=0, `id_nextpc`=1, `id_valid`=0. All combinational outputs are 0 while in reset.
- Decode of `id_instr`:
  - `rs1`=[19:15], `rs2`=[24:20].
  - `rs2` counts as used only for opcodes 0110011, 0100011 and 1100011.
  - `rs1` counts as used for every opcode except 1101111, 0110111 and 0010111.
- JAL target is `id_pc` + (sext(J-imm) >>> 2), 32-bit wrap-around, word-indexed.
- Control priority, highest first, evaluated combinationally every cycle:
  1. `hlt`=1: all control outputs are 0 and the IF/ID register holds.
  2. State is HALTED: `bubble`=1 and the register holds.
  3. `ex_redirect`=1: `jump`=1, `next`=`ex_target`. Next state is SQUASH and the register loads NOP with `id_valid`=0.
  4. Load-use hazard: `id_valid` & `ex_mem_read` & `ex_rd`!=0 & `ex_rd` matches a used `rs1`/`rs2`. Then `stall`=1 and `id_kill`=1, and the register holds.
  5. `id_valid` & opcode=1101111 (JAL): `jump`=1, `next`=JAL target. Next state is SQUASH and the register loads NOP with `id_valid`=0.
  6. `id_valid` & opcode=HALT_OPC: next state is HALTED and the register holds.
  7. Otherwise: the register loads `if_*` with `id_valid`=1.
- SQUASH lasts exactly one cycle, then returns to RUN. Rules 3–6 still apply while in SQUASH; `id_valid`=0 blocks rules 4–6.
- HALTED is sticky until `rst_n` is asserted.
- `next` is 0 whenever `jump`=0.
- NOPs served by the program server during its stall window are captured as valid instructions and are harmless.

## Timing
- IF/ID register update is on `posedge clk`. Reset is asynchronous: the register clears and the state returns to RUN immediately, even mid-SQUASH or mid-stall.
- `jump`, `next`, `stall`, `bubble` and `id_kill` are combinational from registered state and `ex_*`. They must be stable before the edge at which the program server samples them.
- ID latency: 1 cycle from `if_instruction` to `id_instr`.
- Penalties:
  - JAL: 1 squashed slot.
  - EX redirect: 1 squashed slot from this block. Older wrong-path ops downstream are the responsibility of the EX/MEM side.
  - Load-use: `stall` is a 1-cycle pulse per hazard. The hazard clears the next cycle because EX then holds the killed bubble.
- Simultaneous JAL in ID and `ex_redirect`: the EX redirect wins, and the JAL is discarded as wrong-path.
- Simultaneous load-use and JAL: the stall wins, and the JAL is taken the following cycle.

## Structure
- Shared package `rv_pipe_pkg`:
  - opcode constants: JAL, JALR, BRANCH, LOAD, STORE, OP, OP_IMM, LUI, AUIPC, HALT
  - NOP constant
  - stage-state enum {RUN, SQUASH, HALTED}
- One sub-module, `rv_operand_use`. It is combinational: it takes the instruction and returns `rs1`, `rs2`, `rs1_used` and `rs2_used`. It is reused by the forwarding unit.

## Test plan
- Reset mid-run:
  - Stimulus: pulse `rst_n` low between edges.
  - Required: `id_instr`=32'h13, `id_pc`=0 and `id_valid`=0 immediately; state RUN.
- JAL from PC 1:
  - Stimulus: `if_instruction`=32'h014000ef at `if_pc`=1.
  - Required: the next cycle shows `jump`=1, `next`=6; the following cycle shows `id_valid`=0 and `id_instr`=NOP.
- Load-use:
  - Stimulus: `id_instr`=32'h02550533 (mul a0,a0,t0), `ex_mem_read`=1, `ex_rd`=10.
  - Required: `stall`=1 and `id_kill`=1 for exactly 1 cycle, with `id_instr` held; `ex_rd`=0 produces no stall.
- Redirect vs JAL:
  - Stimulus: `ex_redirect`=1 with `ex_target`=14 while `id_instr`=32'hfe1ff0ef.
  - Required: `next`=14, not the JAL target; the following cycle is SQUASH.
- HALT:
  - Stimulus: `id_instr`=32'h0000007f.
  - Required: `bubble`=1 from the next cycle onward, sticky, with `id_instr` frozen; cleared only by `rst_n`.
- Global hlt:
  - Stimulus: `hlt`=1 with a JAL in ID.
  - Required: `jump`=0 and the register holds; the JAL fires once `hlt` deasserts.
